// File: rtl/mips_pkg.sv
// Shared register-file widths and the write-back queue entry type.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(0);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue: two pushes (push0 older) and one pop per cycle.
// With WB_BYPASS_EN defined, all entries are also exposed oldest-first for bypass search.
module wb_fifo
  import mips_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  wb_entry_t        push0_ent,
  input  logic             push1,
  input  wb_entry_t        push1_ent,
  input  logic             pop,
  output wb_entry_t        head_c,
`ifdef WB_BYPASS_EN
  output wb_entry_t        age_ent_c [DEPTH],
  output logic [DEPTH-1:0] age_vld_c,
`endif
  output logic [CNT_W-1:0] count_q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_ptr1_c;
  logic [CNT_W-1:0] count_d;

  // push1 lands behind push0 when both are present; pointers wrap naturally
  always_comb begin
    mem_d     = mem_q;
    wr_ptr1_c = push0 ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    if (push0) mem_d[wr_ptr_q]  = push0_ent;
    if (push1) mem_d[wr_ptr1_c] = push1_ent;
    wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_c = mem_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_ent_c[i] = mem_q[rd_ptr_q + PTR_W'(i)];
      age_vld_c[i] = CNT_W'(i) < count_q;
    end
  end
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into the single register-file write port.
// Define WB_BYPASS_EN to enable the pending-write bypass lookup.
module writeback_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memValid,
  input  logic [ADDR_W-1:0]        memReg,
  input  logic [DATA_W-1:0]        memData,
  output logic                     memReady,
  input  logic                     aluValid,
  input  logic [ADDR_W-1:0]        aluReg,
  input  logic [DATA_W-1:0]        aluData,
  output logic                     aluReady,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        readReg1,
  input  logic [ADDR_W-1:0]        readReg2,
  output logic                     fwdHit1,
  output logic [DATA_W-1:0]        fwdData1,
  output logic                     fwdHit2,
  output logic [DATA_W-1:0]        fwdData2,
  output logic [$clog2(DEPTH):0]   count
);

  import mips_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  free_c;
  logic              mem_nz_c, alu_nz_c;
  logic              mem_ready_c, alu_ready_c;
  logic              push0_c, push1_c, pop_c;
  wb_entry_t         mem_ent_c, alu_ent_c, head_c;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  // Ready depends on occupancy only; zero-register results are always taken and dropped
  always_comb begin
    mem_nz_c       = memValid && (memReg != ZERO_REG);
    alu_nz_c       = aluValid && (aluReg != ZERO_REG);
    free_c         = CNT_W'(DEPTH) - occ;
    mem_ready_c    = (free_c >= CNT_W'(1)) || (memValid && (memReg == ZERO_REG));
    alu_ready_c    = (free_c >= CNT_W'(1) + CNT_W'(mem_nz_c)) ||
                     (aluValid && (aluReg == ZERO_REG));
    push0_c        = mem_nz_c && mem_ready_c;
    push1_c        = alu_nz_c && alu_ready_c;
    pop_c          = occ != '0;
    mem_ent_c.addr = memReg;
    mem_ent_c.data = memData;
    alu_ent_c.addr = aluReg;
    alu_ent_c.data = aluData;
  end

`ifdef WB_BYPASS_EN
  wb_entry_t        age_ent_c [DEPTH];
  logic [DEPTH-1:0] age_vld_c;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push0     (push0_c),
    .push0_ent (mem_ent_c),
    .push1     (push1_c),
    .push1_ent (alu_ent_c),
    .pop       (pop_c),
    .head_c    (head_c),
`ifdef WB_BYPASS_EN
    .age_ent_c (age_ent_c),
    .age_vld_c (age_vld_c),
`endif
    .count_q   (occ)
  );

  always_comb begin
    reg_write_d  = pop_c;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop_c) begin
      write_reg_d  = head_c.addr;
      write_data_d = head_c.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest (output register) to newest (queue tail) so the last match wins
  always_comb begin
    fwdHit1  = 1'b0;
    fwdData1 = '0;
    fwdHit2  = 1'b0;
    fwdData2 = '0;
    if (reg_write_q && (readReg1 != ZERO_REG) && (write_reg_q == readReg1)) begin
      fwdHit1  = 1'b1;
      fwdData1 = write_data_q;
    end
    if (reg_write_q && (readReg2 != ZERO_REG) && (write_reg_q == readReg2)) begin
      fwdHit2  = 1'b1;
      fwdData2 = write_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_vld_c[i] && (readReg1 != ZERO_REG) && (age_ent_c[i].addr == readReg1)) begin
        fwdHit1  = 1'b1;
        fwdData1 = age_ent_c[i].data;
      end
      if (age_vld_c[i] && (readReg2 != ZERO_REG) && (age_ent_c[i].addr == readReg2)) begin
        fwdHit2  = 1'b1;
        fwdData2 = age_ent_c[i].data;
      end
    end
  end
`else
  logic unused_read_c;
  assign unused_read_c = ^{readReg1, readReg2};
  assign fwdHit1  = 1'b0;
  assign fwdData1 = '0;
  assign fwdHit2  = 1'b0;
  assign fwdData2 = '0;
`endif

  assign memReady  = mem_ready_c;
  assign aluReady  = alu_ready_c;
  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign count     = occ;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; bypass expectations follow WB_BYPASS_EN.
module tb_writeback_arbiter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              memValid, aluValid;
  logic [ADDR_W-1:0] memReg, aluReg, readReg1, readReg2;
  logic [DATA_W-1:0] memData, aluData;
  logic              memReady, aluReady, regWrite, fwdHit1, fwdHit2;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData, fwdData1, fwdData2;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2),
    .fwdHit1(fwdHit1), .fwdData1(fwdData1), .fwdHit2(fwdHit2), .fwdData2(fwdData2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    memValid = v; memReg = r; memData = d;
  endtask

  task automatic set_alu(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    aluValid = v; aluReg = r; aluData = d;
  endtask

  initial begin
    set_mem(0, 0, 0);
    set_alu(0, 0, 0);
    readReg1 = '0;
    readReg2 = '0;

    // asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_regWrite",  32'(regWrite),  32'd0);
    chk("rst_writeReg",  32'(writeReg),  32'd0);
    chk("rst_writeData", writeData,      32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_memReady",  32'(memReady),  32'd1);
    chk("rst_aluReady",  32'(aluReady),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_regWrite", 32'(regWrite), 32'd0);

    // single ALU write
    set_alu(1, 3, 32'hAA);
    #1 chk("single_aluReady", 32'(aluReady), 32'd1);
    tick();
    set_alu(0, 0, 0);
    chk("single_count1", 32'(count), 32'd1);
    chk("single_nowrite", 32'(regWrite), 32'd0);
    tick();
    chk("single_regWrite", 32'(regWrite), 32'd1);
    chk("single_writeReg", 32'(writeReg), 32'd3);
    chk("single_writeData", writeData, 32'hAA);
    chk("single_count0", 32'(count), 32'd0);
    readReg1 = 3;
    #1;
    chk("byp_outreg_hit", 32'(fwdHit1), 32'(BYP));
    chk("byp_outreg_data", fwdData1, BYP ? 32'hAA : 32'd0);
    tick();
    chk("single_done", 32'(regWrite), 32'd0);
    chk("single_hold_reg", 32'(writeReg), 32'd3);
    chk("single_hold_data", writeData, 32'hAA);
    readReg1 = 0;

    // dual completion: mem entry is older than the ALU entry
    set_mem(1, 4, 32'h11);
    set_alu(1, 5, 32'h22);
    #1;
    chk("dual_memReady", 32'(memReady), 32'd1);
    chk("dual_aluReady", 32'(aluReady), 32'd1);
    tick();
    set_mem(0, 0, 0);
    set_alu(0, 0, 0);
    chk("dual_count2", 32'(count), 32'd2);
    tick();
    chk("dual_w1_valid", 32'(regWrite), 32'd1);
    chk("dual_w1_reg", 32'(writeReg), 32'd4);
    chk("dual_w1_data", writeData, 32'h11);
    chk("dual_count1", 32'(count), 32'd1);
    tick();
    chk("dual_w2_valid", 32'(regWrite), 32'd1);
    chk("dual_w2_reg", 32'(writeReg), 32'd5);
    chk("dual_w2_data", writeData, 32'h22);
    chk("dual_count0", 32'(count), 32'd0);
    tick();
    chk("dual_done", 32'(regWrite), 32'd0);

    // fill towards the occupancy limit
    set_mem(1, 8, 32'h1);
    set_alu(1, 9, 32'h2);
    tick();
    chk("fill_count2", 32'(count), 32'd2);
    set_mem(1, 10, 32'h3);
    set_alu(1, 11, 32'h4);
    #1 chk("fill_aluReady_free2", 32'(aluReady), 32'd1);
    tick();
    chk("fill_count3", 32'(count), 32'd3);
    chk("fill_out_r8", 32'(writeReg), 32'd8);
    set_mem(1, 12, 32'h5);
    set_alu(1, 13, 32'h6);
    #1;
    chk("full_memReady", 32'(memReady), 32'd1);
    chk("full_aluReady", 32'(aluReady), 32'd0);
    tick();
    set_mem(0, 0, 0);
    chk("full_out_r9", 32'(writeReg), 32'd9);
    chk("full_count3", 32'(count), 32'd3);
    #1 chk("retry_aluReady", 32'(aluReady), 32'd1);
    tick();
    set_alu(0, 0, 0);
    chk("retry_out_r10", 32'(writeReg), 32'd10);
    chk("retry_count3", 32'(count), 32'd3);
    readReg1 = 10;
    readReg2 = 12;
    #1;
    chk("byp_r10_hit", 32'(fwdHit1), 32'(BYP));
    chk("byp_r10_data", fwdData1, BYP ? 32'h3 : 32'd0);
    chk("byp_r12_hit", 32'(fwdHit2), 32'(BYP));
    chk("byp_r12_data", fwdData2, BYP ? 32'h5 : 32'd0);
    readReg1 = 0;
    readReg2 = 0;
    tick();
    chk("drain_r11", 32'(writeReg), 32'd11);
    chk("drain_d11", writeData, 32'h4);
    tick();
    chk("drain_r12", 32'(writeReg), 32'd12);
    tick();
    chk("drain_r13", 32'(writeReg), 32'd13);
    chk("drain_d13", writeData, 32'h6);
    chk("drain_count0", 32'(count), 32'd0);
    tick();
    chk("drain_done", 32'(regWrite), 32'd0);

    // zero-register result is accepted and dropped
    set_alu(1, 0, 32'hFF);
    #1 chk("zero_aluReady", 32'(aluReady), 32'd1);
    tick();
    set_alu(0, 0, 0);
    chk("zero_count", 32'(count), 32'd0);
    tick();
    chk("zero_nowrite", 32'(regWrite), 32'd0);

    // bypass: two pending writes to r7, newest must win
    set_mem(1, 7, 32'h1);
    set_alu(1, 7, 32'h2);
    tick();
    set_mem(0, 0, 0);
    set_alu(0, 0, 0);
    readReg1 = 7;
    readReg2 = 0;
    #1;
    chk("byp_r7_hit", 32'(fwdHit1), 32'(BYP));
    chk("byp_r7_data", fwdData1, BYP ? 32'h2 : 32'd0);
    chk("byp_r0_hit", 32'(fwdHit2), 32'd0);
    chk("byp_r0_data", fwdData2, 32'd0);
    tick();
    chk("byp_r7_q1_data", fwdData1, BYP ? 32'h2 : 32'd0);
    tick();
    chk("byp_r7_out_hit", 32'(fwdHit1), 32'(BYP));
    chk("byp_r7_out_data", fwdData1, BYP ? 32'h2 : 32'd0);
    tick();
    chk("byp_r7_gone", 32'(fwdHit1), 32'd0);
    chk("byp_r7_gone_data", fwdData1, 32'd0);

    // reset while three writes are still queued
    readReg1 = 2;
    set_mem(1, 1, 32'hA1);
    set_alu(1, 2, 32'hA2);
    tick();
    set_mem(1, 14, 32'hA3);
    set_alu(1, 15, 32'hA4);
    tick();
    set_mem(0, 0, 0);
    set_alu(0, 0, 0);
    chk("mid_count3", 32'(count), 32'd3);
    chk("mid_regWrite", 32'(regWrite), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_hit", 32'(fwdHit1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_quiet%0d", i), 32'(regWrite), 32'd0);
    end
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side initiator for the 32x32 register file's single write port.
- Accepts completed results from two producers: the ALU stage and the load/memory stage. Both may complete in the same cycle.
- Buffers results in a small in-order queue and drains one write per cycle onto regWrite/writeReg/writeData.
- Gives the decode stage a bypass lookup so that values still pending in the queue are not read stale from the register file.

Parameters:
- DEPTH, 4, queue entries (power of two, >= 2).
- DATA_W, 32, result data width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- memValid  in  1  load result valid.
- memReg  in  ADDR_W  load destination register.
- memData  in  DATA_W  load result.
- memReady  out  1  load result accepted this cycle when memValid=1.
- aluValid  in  1  ALU result valid.
- aluReg  in  ADDR_W  ALU destination register.
- aluData  in  DATA_W  ALU result.
- aluReady  out  1  ALU result accepted this cycle when aluValid=1.
- regWrite  out  1  write strobe to register file (registered).
- writeReg  out  ADDR_W  write address (registered).
- writeData  out  DATA_W  write data (registered).
- readReg1  in  ADDR_W  bypass lookup address, port 1.
- readReg2  in  ADDR_W  bypass lookup address, port 2.
- fwdHit1  out  1  readReg1 matches a pending write (combinational).
- fwdData1  out  DATA_W  newest pending data for readReg1.
- fwdHit2  out  1  readReg2 matches a pending write.
- fwdData2  out  DATA_W  newest pending data for readReg2.
- count  out  clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (async, rst=1): pointers and count cleared, all queue entries lost.
  - regWrite=0, writeReg=0, writeData=0, count=0.
  - memReady=1, aluReady=1 while free space allows.
  - Reset asserted mid-operation discards pending writes; nothing is written afterwards.
- Handshake: a producer transfers on valid&ready at the rising edge. Ready is combinational from occupancy only, never from the same-cycle pop.
  - free = DEPTH - count.
  - memReady = (free >= 1).
  - aluReady = (free >= 1 + (memValid & memReg!=0)).
- Ordering on a simultaneous accept: the mem entry is enqueued first (it belongs to the older instruction), then the ALU entry. At most 2 enqueues per cycle.
- Zero register: a valid result with destination 0 is handshaken (ready=1 regardless of space) and dropped. It is never enqueued, never written, and never produces a bypass hit.
- Drain: at each edge where the queue is non-empty (state before the edge), the head is popped into the output registers and regWrite=1 for the following cycle. Otherwise regWrite=0, and writeReg/writeData hold their last value.
- Latency: an entry accepted at edge N with an empty queue gives regWrite=1 during cycle N+1..N+2. The register file captures it at edge N+2.
- Push and pop in the same cycle are both performed. count updates by +pushes-pop, range 0..DEPTH, and never overflows because of the ready rules.
- Pointer wrap: read and write pointers wrap modulo DEPTH.
- Bypass: the search set is every queue entry plus the output register while regWrite=1.
  - A hit requires readRegX != 0.
  - The newest matching entry wins; the queue tail is newest and the output register is oldest.
  - Same-cycle incoming producer data is not forwarded.
  - On a miss, fwdDataX=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: bypass lookup is implemented as described above.
- Undefined: fwdHit1=fwdHit2=0 and fwdData1=fwdData2=0 constantly, with no comparator logic. The pipeline must then stall on pending writes externally. All other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0.
  - typedef wb_entry_t {addr[ADDR_W], data[DATA_W]}.
- One sub-module: wb_fifo.
  - Contents: 2-write/1-read circular storage, pointers, count, and exposure of all entries plus an age order for bypass.
  - The arbiter top adds the ready logic, zero-register filtering, the output register and the bypass mux.

Test Plan:
- Reset, then idle: rst pulse mid-cycle -> immediately regWrite=0, writeReg=0, writeData=0, count=0, memReady=aluReady=1.
- Single ALU write: aluValid with aluReg=3, aluData=0x0000_00AA at edge N -> regWrite=1, writeReg=3, writeData=0xAA during N+1..N+2, then regWrite=0.
- Dual completion: memReg=4/0x11 and aluReg=5/0x22 in the same cycle -> writes appear on consecutive cycles, reg4 then reg5; count goes 2, then 1, then 0.
- Full queue: DEPTH=4 filled, count=4 -> memReady=0, aluReady=0. With count=3 and both producers valid -> memReady=1, aluReady=0, and the ALU entry is taken the next cycle.
- Zero register and bypass:
  - aluReg=0/0xFF accepted -> no write and count unchanged.
  - Pending entries reg7=0x1 (older) and reg7=0x2 (newer), readReg1=7 -> fwdHit1=1, fwdData1=0x2.
  - readReg2=0 -> fwdHit2=0.
  - With WB_BYPASS_EN undefined -> fwdHit1=0 in all cases.
- Reset mid-drain: 3 entries queued, rst asserted -> queue emptied, no further regWrite pulses after rst is released.
